// File: rtl/fft_frame_loader.sv
// fft_frame_loader
// Collects windowed frames (N samples followed by zero padding up to NF) into a
// two-bank ping-pong RAM at bit-reversed addresses. Each completed bank is
// streamed to the FFT in natural address order over a valid/ready handshake.
// A two-entry skid after the synchronous RAM read keeps the stream free of
// bubbles under continuous out_ready.
module fft_frame_loader #(
  parameter int N  = 256,
  parameter int NF = 512,
  parameter int DW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DW-1:0]         sample_in,
  input  logic                  sample_valid,
  input  logic                  flush,
  output logic [DW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [$clog2(NF)-1:0] out_index,
  output logic                  overflow
);

  localparam int              AW    = $clog2(NF);
  localparam logic [AW:0]     LIM_N = (AW+1)'(N);
  localparam logic [AW-1:0]   LAST  = AW'(NF - 1);

  typedef enum logic {RD_IDLE, RD_STREAM} rd_state_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // Ping-pong RAM: bank select is the top address bit.
  logic [DW-1:0]   r_mem [2*NF];

  // Write side state
  logic [AW-1:0]   r_wr_cnt;
  logic            r_wr_bank;
  logic            r_overflow;
  logic [1:0]      r_bank_full;

  // Read side state
  rd_state_t       r_state;
  logic            r_rd_bank;
  logic [AW:0]     r_rd_cnt;        // MSB set once every address of the bank is issued
  logic [1:0]      r_sk_cnt;
  logic            r_sk_wptr;
  logic            r_sk_rptr;
  logic [AW-1:0]   r_sk_idx  [2];
  logic [DW-1:0]   r_sk_data [2];
  logic [DW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_out_last;
  logic [AW-1:0]   r_out_index;

  logic            w_wr_blocked;
  logic            w_wr_fire;
  logic            w_wr_wrap;
  logic [DW-1:0]   w_wr_data;
  logic            w_issue;
  logic            w_out_load;
  logic            w_pop;
  logic            w_release;

  assign w_wr_blocked = r_bank_full[r_wr_bank];
  assign w_wr_fire    = sample_valid && !w_wr_blocked && !flush;
  assign w_wr_wrap    = w_wr_fire && (r_wr_cnt == LAST);
  assign w_wr_data    = ({1'b0, r_wr_cnt} < LIM_N) ? sample_in : '0;

  // A read is issued only when the skid has a free entry, so the RAM output
  // never has to be stalled and issue does not depend on out_ready.
  assign w_issue    = (r_state == RD_STREAM) && !r_rd_cnt[AW] && (r_sk_cnt != 2'd2) && !flush;
  assign w_out_load = !r_out_valid || out_ready;
  assign w_pop      = w_out_load && (r_sk_cnt != 2'd0);
  assign w_release  = r_out_valid && out_ready && r_out_last;

  // Write-side counter, bank pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    if (!rst_n) begin
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_cnt   <= '0;
      r_wr_bank  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_fire) begin
        if (w_wr_wrap) begin
          r_wr_cnt  <= '0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= r_wr_cnt + AW'(1);
        end
      end
      // wr_cnt is left alone so the frame resumes once the bank frees
      if (sample_valid && w_wr_blocked) r_overflow <= 1'b1;
    end
  end

  // Bank-full flags: set by the last write of a bank, cleared by the last read.
  // The two events always target different banks, so both may land together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank_full <= '0;
    end else if (flush) begin
      r_bank_full <= '0;
    end else begin
      if (w_wr_wrap) r_bank_full[r_wr_bank] <= 1'b1;
      if (w_release) r_bank_full[r_rd_bank] <= 1'b0;
    end
  end

  // RAM write port and synchronous read into the skid entries.
  always_ff @(posedge clk) begin
    // NOTE: RAM contents and skid data are deliberately not reset; validity
    // is tracked by the reset flags, which keeps the arrays mappable to RAM.
    if (w_wr_fire) r_mem[{r_wr_bank, bitrev(r_wr_cnt)}] <= w_wr_data;
    if (w_issue)   r_sk_data[r_sk_wptr] <= r_mem[{r_rd_bank, r_rd_cnt[AW-1:0]}];
  end

  // Read FSM, skid bookkeeping and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RD_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_sk_cnt    <= 2'd0;
      r_sk_wptr   <= 1'b0;
      r_sk_rptr   <= 1'b0;
      r_sk_idx[0] <= '0;
      r_sk_idx[1] <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_index <= '0;
    end else if (flush) begin
      r_state     <= RD_IDLE;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_sk_cnt    <= 2'd0;
      r_sk_wptr   <= 1'b0;
      r_sk_rptr   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_index <= '0;
    end else begin
      if (w_issue) begin
        r_sk_idx[r_sk_wptr] <= r_rd_cnt[AW-1:0];
        r_sk_wptr           <= ~r_sk_wptr;
        r_rd_cnt            <= r_rd_cnt + (AW+1)'(1);
      end
      if (w_pop) r_sk_rptr <= ~r_sk_rptr;
      case ({w_issue, w_pop})
        2'b10:   r_sk_cnt <= r_sk_cnt + 2'd1;
        2'b01:   r_sk_cnt <= r_sk_cnt - 2'd1;
        default: r_sk_cnt <= r_sk_cnt;
      endcase

      if (w_out_load) begin
        r_out_valid <= w_pop;
        if (w_pop) begin
          r_out_data  <= r_sk_data[r_sk_rptr];
          r_out_index <= r_sk_idx[r_sk_rptr];
          r_out_last  <= (r_sk_idx[r_sk_rptr] == LAST);
        end else begin
          r_out_last  <= 1'b0;
        end
      end

      case (r_state)
        RD_IDLE: begin
          if (r_bank_full[r_rd_bank]) begin
            r_state  <= RD_STREAM;
            r_rd_cnt <= '0;
          end
        end
        RD_STREAM: begin
          // Chain straight into the other bank when it is already full
          if (w_release) begin
            r_rd_bank <= ~r_rd_bank;
            r_rd_cnt  <= '0;
            r_state   <= r_bank_full[~r_rd_bank] ? RD_STREAM : RD_IDLE;
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_index = r_out_index;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_fft_frame_loader.sv
// tb_fft_frame_loader
// Directed sequence with random sample data. A frame-level model (queue of
// accepted samples, count of completed-but-unreleased frames) predicts which
// samples are kept, the streamed word order and the sticky overflow flag.
module tb_fft_frame_loader;

  localparam int N  = 256;
  localparam int NF = 512;
  localparam int DW = 16;
  localparam int AW = $clog2(NF);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [DW-1:0]        sample_in;
  logic                 sample_valid;
  logic                 flush;
  logic [DW-1:0]        out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [AW-1:0]        out_index;
  logic                 overflow;

  always #5 clk = ~clk;

  fft_frame_loader #(.N(N), .NF(NF), .DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_index    (out_index),
    .overflow     (overflow)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } word_t;

  word_t         exp_q[$];     // words still to be streamed, in stream order
  logic [DW-1:0] cur[$];       // accepted samples of the frame being collected
  int            held;         // completed frames not yet released by the reader
  logic          ovf_m;
  int            checks = 0;
  int            errors = 0;
  int            step_no = 0;
  int            frame_done_step = 0;
  int            rise_step = 0;
  int            rel_step = 0;
  int            hs_cnt = 0;
  int            frames_done = 0;
  logic          prev_valid = 1'b0;

  // Bit reversal by repeated halving of the index.
  function automatic int bitrev(input int v);
    int x;
    int r;
    x = v;
    r = 0;
    for (int b = 0; b < AW; b++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    cur.delete();
    held  = 0;
    ovf_m = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, score any handshake, advance the model.
  // Called and returning 1 time unit after a rising edge.
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic rdy, input logic fl);
    word_t w;
    logic  acc;
    logic  rel;
    int    s;
    s            = step_no;
    sample_valid = sv;
    sample_in    = sd;
    out_ready    = rdy;
    flush        = fl;
    rel          = 1'b0;
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (out_valid && !prev_valid) rise_step = s;
    prev_valid = out_valid;
    if (out_valid && rdy && !fl) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 32'(out_valid), 32'(0));
      end else begin
        w = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(w.data));
        check("out_index", 32'(out_index), 32'(w.idx));
        check("out_last", 32'(out_last), 32'(w.idx == NF - 1));
        hs_cnt++;
        if (w.idx == NF - 1) begin
          rel      = 1'b1;
          rel_step = s;
        end
      end
    end
    acc = sv && !fl && (held < 2);
    if (sv && !fl && held >= 2) ovf_m = 1'b1;
    @(posedge clk);
    #1;
    step_no++;
    if (fl) begin
      model_reset();
    end else begin
      if (rel) held--;
      if (acc) begin
        cur.push_back((cur.size() < N) ? sd : '0);
        if (cur.size() == NF) begin
          for (int i = 0; i < NF; i++) begin
            w.data = cur[bitrev(i)];
            w.idx  = i;
            exp_q.push_back(w);
          end
          cur.delete();
          held++;
          frames_done++;
          frame_done_step = s;
        end
      end
    end
  endtask

  task automatic send_samples(input int count, input bit ramp, input logic rdy);
    for (int k = 0; k < count; k++)
      step(1'b1, ramp ? DW'(k + 1) : DW'($urandom), rdy, 1'b0);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic wait_index(input int idx, input string tag);
    int n;
    n = 0;
    while (!(out_valid && int'(out_index) == idx) && n < 2000) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    check(tag, 32'(out_index), 32'(idx));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_data"},  32'(out_data),  32'(0));
    check({tag, "_index"}, 32'(out_index), 32'(0));
    check({tag, "_last"},  32'(out_last),  32'(0));
    check({tag, "_ovf"},   32'(overflow),  32'(0));
  endtask

  // Ramp frame with free-running consumer. The full flag becomes visible one
  // edge after the last write; the FSM enters RD_STREAM on the next edge and
  // out_valid follows two edges later, i.e. 4 steps after the last write step.
  task automatic ramp_frame(input string tag);
    hs_cnt = 0;
    send_samples(NF, 1'b1, 1'b1);
    drain({tag, "_drain"});
    check({tag, "_latency"}, 32'(rise_step - frame_done_step), 32'(4));
    check({tag, "_count"}, 32'(hs_cnt), 32'(NF));
  endtask

  initial begin
    int   n;
    int   target;
    int   r1;
    logic tog;

    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    rst_n = 1'b1;

    // 1: ramp frame, no stall
    ramp_frame("t1");

    // 2: stall 5 cycles at index 7, then toggle ready
    hs_cnt = 0;
    send_samples(NF, 1'b0, 1'b1);
    wait_index(7, "t2_reach7");
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      check("t2_stall_valid", 32'(out_valid), 32'(1));
      check("t2_stall_index", 32'(out_index), 32'(7));
      check("t2_stall_data",  32'(out_data),  32'(exp_q[0].data));
      check("t2_stall_last",  32'(out_last),  32'(0));
    end
    tog = 1'b1;
    n   = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      step(1'b0, '0, tog, 1'b0);
      tog = ~tog;
      n++;
    end
    check("t2_drain", 32'(exp_q.size()), 32'(0));
    check("t2_count", 32'(hs_cnt), 32'(NF));

    // 3: three back-to-back frames, consumer stalled until frame 3 starts
    hs_cnt = 0;
    target = frames_done + 3;
    send_samples(2 * NF, 1'b0, 1'b0);
    send_samples(100, 1'b0, 1'b0);
    check("t3_ovf_set", 32'(overflow), 32'(1));
    send_samples(NF - 100, 1'b0, 1'b1);
    n = 0;
    while (frames_done < target && n < 3000) begin
      step(1'b1, DW'($urandom), 1'b1, 1'b0);
      n++;
    end
    check("t3_frames", 32'(frames_done), 32'(target));
    drain("t3_drain");
    check("t3_count", 32'(hs_cnt), 32'(3 * NF));
    check("t3_ovf_sticky", 32'(overflow), 32'(1));

    // 4: two frames back-to-back with continuous ready
    step(1'b0, '0, 1'b1, 1'b1);
    hs_cnt = 0;
    send_samples(2 * NF, 1'b0, 1'b1);
    n = 0;
    while (hs_cnt < NF && n < 2000) begin
      step(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    r1 = rel_step;
    drain("t4_drain");
    check("t4_gap", 32'(rise_step - r1), 32'(3));
    check("t4_count", 32'(hs_cnt), 32'(2 * NF));

    // 5a: flush while streaming at read index 100 with overflow set
    send_samples(2 * NF, 1'b0, 1'b0);
    step(1'b1, DW'($urandom), 1'b0, 1'b0);
    check("t5_ovf_set", 32'(overflow), 32'(1));
    wait_index(100, "t5_reach100");
    step(1'b0, '0, 1'b0, 1'b1);
    check_cleared("t5a_flush");

    // 5b: flush at write index 300, then a gappy frame starting at index 0
    send_samples(300, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    check_cleared("t5b_flush");
    hs_cnt = 0;
    target = frames_done + 1;
    n = 0;
    while (frames_done < target && n < 3000) begin
      step(($urandom % 4) != 0, DW'($urandom), 1'b1, 1'b0);
      n++;
    end
    drain("t5b_drain");
    check("t5b_count", 32'(hs_cnt), 32'(NF));

    // 6: asynchronous reset mid-stream, between clock edges
    send_samples(NF, 1'b1, 1'b1);
    wait_index(50, "t6_reach50");
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'(0));
    check("t6_async_index", 32'(out_index), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    prev_valid = out_valid;
    ramp_frame("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
